// File: rtl/rank_filter_3x3.sv
// rank_filter_3x3: 3-stage free-running 3x3 min / median / max / bypass filter.
// Each window carries its own mode tag, so a mode change only takes effect at
// a frame start. A post-side pixel counter reports the valid pixel count of
// each completed output frame.
module rank_filter_3x3 #(
    parameter int DATA_W       = 8,
    parameter int CNT_W        = 20,
    parameter int ZERO_INVALID = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_href,
    input  logic              pre_frame_clken,
    input  logic [DATA_W-1:0] data11,
    input  logic [DATA_W-1:0] data12,
    input  logic [DATA_W-1:0] data13,
    input  logic [DATA_W-1:0] data21,
    input  logic [DATA_W-1:0] data22,
    input  logic [DATA_W-1:0] data23,
    input  logic [DATA_W-1:0] data31,
    input  logic [DATA_W-1:0] data32,
    input  logic [DATA_W-1:0] data33,
    output logic [DATA_W-1:0] target_data,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [1:0]        mode_active,
    output logic [CNT_W-1:0]  frame_pix_cnt,
    output logic              frame_done
);

    localparam logic [1:0] M_MIN = 2'b00;
    localparam logic [1:0] M_MED = 2'b01;
    localparam logic [1:0] M_MAX = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_mid(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
        return f_max(f_min(a, b), f_min(f_max(a, b), c));
    endfunction

    // window rows, column 1 in [0]
    logic [2:0][2:0][DATA_W-1:0] w_row;
    assign w_row[0] = {data13, data12, data11};
    assign w_row[1] = {data23, data22, data21};
    assign w_row[2] = {data33, data32, data31};

    // frame-start detect and per-window mode tag
    logic       r_vs_prev;
    logic       w_vs_rise;
    logic [1:0] w_tag;
    assign w_vs_rise = pre_frame_vsync & ~r_vs_prev;
    assign w_tag     = w_vs_rise ? cfg_mode : mode_active;

    // Stage 1 registers
    logic [2:0][DATA_W-1:0] r_rmax, r_rmid, r_rmin;
    logic [DATA_W-1:0]      r_ctr1;
    logic [1:0]             r_tag1;
    logic                   r_vs1, r_hr1, r_ck1, r_sk1;

    // Stage 2 registers
    logic [DATA_W-1:0] r_maxmax, r_minmax, r_medmid, r_maxmin, r_minmin, r_ctr2;
    logic [1:0]        r_tag2;
    logic              r_vs2, r_hr2, r_ck2, r_sk2;

    // Frames cut short by reset are flagged so they never report frame_done:
    // the flag is raised by reset and dropped once the input vsync is seen low.
    logic r_skip;

    // edge detect, mode latch and abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev   <= 1'b0;
            mode_active <= M_MED;
            r_skip      <= 1'b1;
        end else begin
            r_vs_prev <= pre_frame_vsync;
            if (w_vs_rise)
                mode_active <= cfg_mode;
            if (!pre_frame_vsync)
                r_skip <= 1'b0;
        end
    end

    // stage 1: per-row sort, sideband delay 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rmax <= '0;
            r_rmid <= '0;
            r_rmin <= '0;
            r_ctr1 <= '0;
            r_tag1 <= '0;
            r_vs1  <= 1'b0;
            r_hr1  <= 1'b0;
            r_ck1  <= 1'b0;
            r_sk1  <= 1'b0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                r_rmax[r] <= f_max(f_max(w_row[r][0], w_row[r][1]), w_row[r][2]);
                r_rmid[r] <= f_mid(w_row[r][0], w_row[r][1], w_row[r][2]);
                r_rmin[r] <= f_min(f_min(w_row[r][0], w_row[r][1]), w_row[r][2]);
            end
            r_ctr1 <= data22;
            r_tag1 <= w_tag;
            r_vs1  <= pre_frame_vsync;
            r_hr1  <= pre_frame_href;
            r_ck1  <= pre_frame_clken;
            r_sk1  <= r_skip;
        end
    end

    // stage 2: column reductions across the row results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_maxmax <= '0;
            r_minmax <= '0;
            r_medmid <= '0;
            r_maxmin <= '0;
            r_minmin <= '0;
            r_ctr2   <= '0;
            r_tag2   <= '0;
            r_vs2    <= 1'b0;
            r_hr2    <= 1'b0;
            r_ck2    <= 1'b0;
            r_sk2    <= 1'b0;
        end else begin
            r_maxmax <= f_max(f_max(r_rmax[0], r_rmax[1]), r_rmax[2]);
            r_minmax <= f_min(f_min(r_rmax[0], r_rmax[1]), r_rmax[2]);
            r_medmid <= f_mid(r_rmid[0], r_rmid[1], r_rmid[2]);
            r_maxmin <= f_max(f_max(r_rmin[0], r_rmin[1]), r_rmin[2]);
            r_minmin <= f_min(f_min(r_rmin[0], r_rmin[1]), r_rmin[2]);
            r_ctr2   <= r_ctr1;
            r_tag2   <= r_tag1;
            r_vs2    <= r_vs1;
            r_hr2    <= r_hr1;
            r_ck2    <= r_ck1;
            r_sk2    <= r_sk1;
        end
    end

    // stage 3 result select by the window's own tag
    logic [DATA_W-1:0] w_res;
    always_comb begin
        w_res = r_ctr2;
        case (r_tag2)
            M_MIN:   w_res = r_minmin;
            M_MED:   w_res = f_mid(r_minmax, r_medmid, r_maxmin);
            M_MAX:   w_res = r_maxmax;
            default: w_res = r_ctr2;
        endcase
    end

    // stage 3: output register and sideband delay 3
    always_ff @(posedge clk) begin
        if (rst) begin
            target_data      <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
        end else begin
            target_data      <= (ZERO_INVALID != 0 && !r_ck2) ? '0 : w_res;
            post_frame_vsync <= r_vs2;
            post_frame_href  <= r_hr2;
            post_frame_clken <= r_ck2;
        end
    end

    // Frame accounting looks at the stage-2 sideband (what post_* shows next
    // cycle), so frame_done and frame_pix_cnt land together with the
    // post_frame_vsync fall and include that cycle's pixel.
    logic             r_fvs;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fvs_nxt, w_frise, w_ffall, w_pv;
    logic [CNT_W-1:0] w_cnt_inc, w_cnt_nxt;

    assign w_pv      = r_ck2 & r_hr2;
    assign w_fvs_nxt = r_vs2 & ~r_sk2;
    assign w_frise   = w_fvs_nxt & ~r_fvs;
    assign w_ffall   = ~w_fvs_nxt & r_fvs;
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;
    assign w_cnt_nxt = w_frise ? (w_pv ? CNT_ONE : '0) : (w_pv ? w_cnt_inc : r_cnt);

    // pixel counter, frame report and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fvs         <= 1'b0;
            r_cnt         <= '0;
            frame_pix_cnt <= '0;
            frame_done    <= 1'b0;
        end else begin
            r_fvs      <= w_fvs_nxt;
            r_cnt      <= w_cnt_nxt;
            frame_done <= w_ffall;
            if (w_ffall)
                frame_pix_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3: modes, mid-frame mode change, frame
// counting with saturation, and reset mid-frame.
module tb_rank_filter_3x3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cfg_mode;
    logic       vs, hr, ck;
    logic [7:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;

    logic [7:0]  t1, t2;
    logic        pvs1, phr1, pck1, pvs2, phr2, pck2;
    logic [1:0]  ma1, ma2;
    logic [19:0] cnt1;
    logic [3:0]  cnt2;
    logic        done1, done2;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    rank_filter_3x3 #(.DATA_W(8), .CNT_W(20), .ZERO_INVALID(1)) u1 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_clken(ck),
        .data11(d11), .data12(d12), .data13(d13),
        .data21(d21), .data22(d22), .data23(d23),
        .data31(d31), .data32(d32), .data33(d33),
        .target_data(t1), .post_frame_vsync(pvs1), .post_frame_href(phr1),
        .post_frame_clken(pck1), .mode_active(ma1), .frame_pix_cnt(cnt1),
        .frame_done(done1)
    );

    rank_filter_3x3 #(.DATA_W(8), .CNT_W(4), .ZERO_INVALID(0)) u2 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_clken(ck),
        .data11(d11), .data12(d12), .data13(d13),
        .data21(d21), .data22(d22), .data23(d23),
        .data31(d31), .data32(d32), .data33(d33),
        .target_data(t2), .post_frame_vsync(pvs2), .post_frame_href(phr2),
        .post_frame_clken(pck2), .mode_active(ma2), .frame_pix_cnt(cnt2),
        .frame_done(done2)
    );

    // count every cycle the main instance reports a finished frame
    always @(posedge clk) if (done1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [71:0] w);
        {d11, d12, d13, d21, d22, d23, d31, d32, d33} = w;
    endtask

    // one-pixel frame: pixel sits on the vsync rising edge cycle
    task automatic run_pix(input string tag, input logic [1:0] m, input logic [71:0] w, input logic [7:0] exp);
        vs = 1'b0; hr = 1'b0; ck = 1'b0;
        tick;
        vs = 1'b1; hr = 1'b1; ck = 1'b1; cfg_mode = m; set_win(w);
        tick;
        hr = 1'b0; ck = 1'b0;
        tick;
        tick;
        chk({tag, "_data"}, 32'(t1), 32'(exp));
        chk({tag, "_clken"}, 32'(pck1), 32'd1);
        chk({tag, "_mode"}, 32'(ma1), 32'(m));
        tick;
        chk({tag, "_zero_inv"}, 32'(t1), 32'd0);
        chk({tag, "_keep_inv"}, 32'(t2), 32'(exp));
    endtask

    task automatic run_frame(input string tag, input int lines, input int ppl,
                             input logic [31:0] exp1, input logic [31:0] exp2);
        int d0;
        vs = 1'b0; hr = 1'b0; ck = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        d0 = done_cnt;
        vs = 1'b1;
        tick;
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < ppl; p++) begin
                hr = 1'b1; ck = 1'b1;
                tick;
            end
            hr = 1'b0; ck = 1'b0;
            tick;
            tick;
        end
        vs = 1'b0;
        tick;
        tick;
        chk({tag, "_done_early"}, 32'(done1), 32'd0);
        tick;
        chk({tag, "_done"}, 32'(done1), 32'd1);
        chk({tag, "_cnt"}, 32'(cnt1), exp1);
        chk({tag, "_cnt_sat"}, 32'(cnt2), exp2);
        tick;
        chk({tag, "_done_late"}, 32'(done1), 32'd0);
        tick;
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    localparam logic [71:0] W1 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [71:0] W2 = {8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0};
    localparam logic [71:0] W3 = {8'd3, 8'd200, 8'd17, 8'd45, 8'd45, 8'd90, 8'd1, 8'd250, 8'd128};

    initial begin
        int d0;
        rst = 1'b1; cfg_mode = 2'b00; vs = 1'b0; hr = 1'b0; ck = 1'b0;
        set_win(W1);
        tick;
        tick;
        chk("rst_data", 32'(t1), 32'd0);
        chk("rst_clken", 32'(pck1), 32'd0);
        chk("rst_mode", 32'(ma1), 32'd1);
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        rst = 1'b0;
        tick;

        run_pix("w1_min", 2'b00, W1, 8'd1);
        run_pix("w1_max", 2'b10, W1, 8'd9);
        run_pix("w1_med", 2'b01, W1, 8'd5);
        run_pix("w1_byp", 2'b11, W1, 8'd5);
        run_pix("w2_med", 2'b01, W2, 8'd255);
        run_pix("w3_min", 2'b00, W3, 8'd1);
        run_pix("w3_max", 2'b10, W3, 8'd250);
        run_pix("w3_med", 2'b01, W3, 8'd45);

        // mode change mid-frame is ignored until the next frame start
        vs = 1'b0; hr = 1'b0; ck = 1'b0; cfg_mode = 2'b00;
        tick;
        vs = 1'b1;
        tick;
        cfg_mode = 2'b10; hr = 1'b1; ck = 1'b1; set_win(W1);
        tick;
        hr = 1'b0; ck = 1'b0;
        tick;
        tick;
        chk("mid_still_min", 32'(t1), 32'd1);
        chk("mid_mode_hold", 32'(ma1), 32'd0);
        run_pix("next_max", 2'b10, W1, 8'd9);

        run_frame("f24", 4, 6, 32'd24, 32'd15);
        run_frame("f20", 4, 5, 32'd20, 32'd15);

        // reset pulse in the middle of a frame
        vs = 1'b0; hr = 1'b0; ck = 1'b0; cfg_mode = 2'b10;
        for (int i = 0; i < 6; i++) tick;
        vs = 1'b1;
        tick;
        d0 = done_cnt;
        hr = 1'b1; ck = 1'b1; set_win(W1);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("ab_clken", 32'(pck1), 32'd0);
        chk("ab_href", 32'(phr1), 32'd0);
        chk("ab_vsync", 32'(pvs1), 32'd0);
        chk("ab_data", 32'(t1), 32'd0);
        chk("ab_mode", 32'(ma1), 32'd1);
        tick;
        chk("ab_clken2", 32'(pck1), 32'd0);
        tick;
        chk("ab_clken3", 32'(pck1), 32'd0);
        tick;
        chk("ab_refill_clken", 32'(pck1), 32'd1);
        chk("ab_refill_data", 32'(t1), 32'd9);
        tick;
        vs = 1'b0; hr = 1'b0; ck = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        chk("ab_no_done", 32'(done_cnt - d0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
